// File: rtl/mul_cell_arbiter_if.sv
// Request, response and multiplier-cell signals shared between the requesters,
// the arbiter and the cell.
interface mul_cell_arbiter_if;
  logic        req_valid_0;
  logic        req_valid_1;
  logic        req_ready_0;
  logic        req_ready_1;
  logic [31:0] req_src1_0;
  logic [31:0] req_src1_1;
  logic [31:0] req_src2_0;
  logic [31:0] req_src2_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        busy;
  logic [31:0] E_src1;
  logic [31:0] E_src2;
  logic        M_en;
  logic [31:0] M_mul_cell_p1;
  logic [31:0] M_mul_cell_p2;
  logic [31:0] M_mul_cell_p3;

  modport master (
    output req_valid_0, req_valid_1, req_src1_0, req_src1_1, req_src2_0, req_src2_1,
    output rsp_ready, M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    input  req_ready_0, req_ready_1, rsp_valid, rsp_id, rsp_result, busy,
    input  E_src1, E_src2, M_en
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_src1_0, req_src1_1, req_src2_0, req_src2_1,
    input  rsp_ready, M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    output req_ready_0, req_ready_1, rsp_valid, rsp_id, rsp_result, busy,
    output E_src1, E_src2, M_en
  );
endinterface

// File: rtl/mul_cell_arbiter.sv
// Round-robin arbiter sharing one three-partial-product multiplier cell between
// two requesters; one 32x32 (low-word) multiply in flight at a time.
//
// state | meaning
// IDLE  | ready to grant a request
// MUL   | operands presented, cell enabled for one cycle
// SUM   | partial products combined into the result register
// RSP   | result offered until rsp_ready
module mul_cell_arbiter (
  input  logic                clk,
  input  logic                reset_n,
  mul_cell_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, MUL, SUM, RSP} state_e;

  state_e      state_q, state_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        cur_id_q, cur_id_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_id_q, rsp_id_d;

  logic        in_idle;
  logic        gnt_0;
  logic        gnt_1;
  logic [15:0] cross_sum;

  // Outputs are gated by reset_n so nothing is offered while reset is held.
  assign in_idle = reset_n && (state_q == IDLE);
  assign gnt_0   = in_idle && bus.req_valid_0 && (!bus.req_valid_1 || last_grant_q);
  assign gnt_1   = in_idle && bus.req_valid_1 && (!bus.req_valid_0 || !last_grant_q);

  assign bus.req_ready_0 = gnt_0;
  assign bus.req_ready_1 = gnt_1;
  assign bus.rsp_valid   = reset_n && (state_q == RSP);
  assign bus.busy        = reset_n && (state_q != IDLE);
  assign bus.M_en        = reset_n && (state_q == MUL);
  assign bus.E_src1      = op1_q;
  assign bus.E_src2      = op2_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_id      = rsp_id_q;

  // Only the low halves of the cross terms reach the low product word.
  assign cross_sum = bus.M_mul_cell_p2[15:0] + bus.M_mul_cell_p3[15:0];

  always_comb begin
    state_d      = state_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    cur_id_d     = cur_id_q;
    last_grant_d = last_grant_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (gnt_0 || gnt_1) begin
          op1_d        = gnt_1 ? bus.req_src1_1 : bus.req_src1_0;
          op2_d        = gnt_1 ? bus.req_src2_1 : bus.req_src2_0;
          cur_id_d     = gnt_1;
          last_grant_d = gnt_1;
          state_d      = MUL;
        end
      end
      MUL: state_d = SUM;
      SUM: begin
        rsp_result_d = bus.M_mul_cell_p1 + {cross_sum, 16'h0000};
        rsp_id_d     = cur_id_q;
        state_d      = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      op1_q        <= 32'h0;
      op2_q        <= 32'h0;
      cur_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_result_q <= 32'h0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      cur_id_q     <= cur_id_d;
      last_grant_q <= last_grant_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_mul_cell_arbiter.sv
// Directed bench for mul_cell_arbiter with a behavioural multiplier cell.
module tb_mul_cell_arbiter;
  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  mul_cell_arbiter_if bus();

  mul_cell_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell model: registers the three partial products when enabled.
  always_ff @(posedge clk) begin
    if (bus.M_en) begin
      bus.M_mul_cell_p1 <= {16'h0, bus.E_src1[15:0]}  * {16'h0, bus.E_src2[15:0]};
      bus.M_mul_cell_p2 <= {16'h0, bus.E_src1[15:0]}  * {16'h0, bus.E_src2[31:16]};
      bus.M_mul_cell_p3 <= {16'h0, bus.E_src1[31:16]} * {16'h0, bus.E_src2[15:0]};
    end
  end

  // Requesters must hold valid until accepted.
  logic pend_0, pend_1;
  initial begin pend_0 = 1'b0; pend_1 = 1'b0; end
  always @(posedge clk) begin
    if (reset_n && pend_0 && !bus.req_valid_0) $error("protocol violation: req_valid_0 dropped before ready");
    if (reset_n && pend_1 && !bus.req_valid_1) $error("protocol violation: req_valid_1 dropped before ready");
    pend_0 <= reset_n && bus.req_valid_0 && !bus.req_ready_0;
    pend_1 <= reset_n && bus.req_valid_1 && !bus.req_ready_1;
  end

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, output bit to);
    to = 1'b1;
    if (id) begin bus.req_src1_1 = a; bus.req_src2_1 = b; bus.req_valid_1 = 1'b1; end
    else    begin bus.req_src1_0 = a; bus.req_src2_0 = b; bus.req_valid_0 = 1'b1; end
    for (int i = 0; i < 30; i++) begin
      #1;
      if ((id ? bus.req_ready_1 : bus.req_ready_0) === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    if (id) bus.req_valid_1 = 1'b0; else bus.req_valid_0 = 1'b0;
  endtask

  task automatic wait_rsp(output bit to);
    to = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid === 1'b1) begin to = 1'b0; break; end
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_valid_0 = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (bus.req_ready_0 !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.M_en !== 1'b0)
      begin miscompares++; $display("FAIL reset_outputs: ready0=%b busy=%b rsp_valid=%b M_en=%b, want all 0",
        bus.req_ready_0, bus.busy, bus.rsp_valid, bus.M_en); end
    bus.req_valid_0 = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b1;
    vectors++;
    if (bus.rsp_result !== 32'h0 || bus.rsp_id !== 1'b0 || bus.E_src1 !== 32'h0 || bus.E_src2 !== 32'h0)
      begin miscompares++; $display("FAIL reset_regs: result=%h id=%b E1=%h E2=%h, want 0", bus.rsp_result,
        bus.rsp_id, bus.E_src1, bus.E_src2); end
  endtask

  task automatic test_single();
    bus.req_src1_0 = 32'h0001_2345; bus.req_src2_0 = 32'h0000_0010; bus.req_valid_0 = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready_0 !== 1'b1 || bus.req_ready_1 !== 1'b0 || bus.M_en !== 1'b0)
      begin miscompares++; $display("FAIL single_grant: ready0=%b ready1=%b M_en=%b, want 1 0 0",
        bus.req_ready_0, bus.req_ready_1, bus.M_en); end
    @(negedge clk); #1;
    bus.req_valid_0 = 1'b0;
    vectors++;
    if (bus.M_en !== 1'b1 || bus.E_src1 !== 32'h0001_2345 || bus.E_src2 !== 32'h10 || bus.busy !== 1'b1)
      begin miscompares++; $display("FAIL single_mul: M_en=%b E1=%h E2=%h busy=%b, want 1 00012345 00000010 1",
        bus.M_en, bus.E_src1, bus.E_src2, bus.busy); end
    @(negedge clk); #1;
    vectors++;
    if (bus.M_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1)
      begin miscompares++; $display("FAIL single_sum: M_en=%b rsp_valid=%b busy=%b, want 0 0 1",
        bus.M_en, bus.rsp_valid, bus.busy); end
    @(negedge clk); #1;
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h0012_3450 || bus.rsp_id !== 1'b0)
      begin miscompares++; $display("FAIL single_rsp: valid=%b result=%h id=%b, want 1 00123450 0",
        bus.rsp_valid, bus.rsp_result, bus.rsp_id); end
    @(negedge clk); #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
      begin miscompares++; $display("FAIL single_idle: rsp_valid=%b busy=%b, want 0 0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_wrap();
    logic [31:0] a_t [3];
    logic [31:0] b_t [3];
    logic [31:0] e_t [3];
    bit to;
    a_t[0] = 32'hFFFF_FFFF; b_t[0] = 32'hFFFF_FFFF; e_t[0] = 32'h0000_0001;
    a_t[1] = 32'h0001_0000; b_t[1] = 32'h0001_0000; e_t[1] = 32'h0000_0000;
    a_t[2] = 32'h0000_FFFF; b_t[2] = 32'h0001_0001; e_t[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      issue(i[0], a_t[i], b_t[i], to);
      if (!to) wait_rsp(to);
      vectors++;
      if (to || bus.rsp_result !== e_t[i] || bus.rsp_id !== i[0])
        begin miscompares++; $display("FAIL wrap_%0d: timeout=%b result=%h id=%b, want %h id %b",
          i, to, bus.rsp_result, bus.rsp_id, e_t[i], i[0]); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_contention();
    int gid [4];
    int gcyc [4];
    logic [31:0] expq [$];
    int idq [$];
    int gcount, rcount, n0, n1;
    bit upd0, upd1;
    apply_reset();
    bus.rsp_ready = 1'b1;
    gcount = 0; rcount = 0; n0 = 0; n1 = 0; upd0 = 1'b0; upd1 = 1'b0;
    bus.req_src1_0 = 32'h0001_0003; bus.req_src2_0 = 32'hFFFF_0002; bus.req_valid_0 = 1'b1;
    bus.req_src1_1 = 32'h8000_00FF; bus.req_src2_1 = 32'h0003_0005; bus.req_valid_1 = 1'b1;
    for (int cyc = 0; cyc < 60 && rcount < 4; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (upd0) begin
        upd0 = 1'b0;
        if (n0 == 2) bus.req_valid_0 = 1'b0;
        else bus.req_src1_0 = 32'h0001_0003 + 32'h11 * n0;
      end
      if (upd1) begin
        upd1 = 1'b0;
        if (n1 == 2) bus.req_valid_1 = 1'b0;
        else bus.req_src1_1 = 32'h8000_00FF - n1;
      end
      #1;
      if (bus.req_ready_0 === 1'b1 && gcount < 4) begin
        gid[gcount] = 0; gcyc[gcount] = cyc; gcount++; n0++; upd0 = 1'b1;
        expq.push_back(bus.req_src1_0 * bus.req_src2_0); idq.push_back(0);
      end
      if (bus.req_ready_1 === 1'b1 && gcount < 4) begin
        gid[gcount] = 1; gcyc[gcount] = cyc; gcount++; n1++; upd1 = 1'b1;
        expq.push_back(bus.req_src1_1 * bus.req_src2_1); idq.push_back(1);
      end
      if (bus.rsp_valid === 1'b1 && expq.size() > 0) begin
        logic [31:0] er;
        int ei;
        er = expq.pop_front(); ei = idq.pop_front();
        vectors++;
        if (bus.rsp_result !== er || bus.rsp_id !== ei[0])
          begin miscompares++; $display("FAIL contention_rsp_%0d: result=%h id=%b, want %h id %0d",
            rcount, bus.rsp_result, bus.rsp_id, er, ei); end
        rcount++;
      end
    end
    vectors++;
    if (gcount != 4 || rcount != 4)
      begin miscompares++; $display("FAIL contention_count: grants=%0d responses=%0d, want 4 4", gcount, rcount); end
    for (int i = 0; i < gcount; i++) begin
      vectors++;
      if (gid[i] != (i % 2))
        begin miscompares++; $display("FAIL contention_order_%0d: got requester %0d, want %0d", i, gid[i], i % 2); end
      if (i > 0) begin
        vectors++;
        if (gcyc[i] - gcyc[i-1] != 4)
          begin miscompares++; $display("FAIL contention_spacing_%0d: got %0d cycles, want 4", i, gcyc[i] - gcyc[i-1]); end
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit to;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0007, 32'h0000_0006, to);
    if (!to) wait_rsp(to);
    vectors++;
    if (to || bus.rsp_result !== 32'd42 || bus.rsp_id !== 1'b0)
      begin miscompares++; $display("FAIL bp_rsp: timeout=%b result=%h id=%b, want 0000002a id 0",
        to, bus.rsp_result, bus.rsp_id); end
    bus.req_src1_1 = 32'h0000_0100; bus.req_src2_1 = 32'h0000_0100; bus.req_valid_1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd42 || bus.rsp_id !== 1'b0 ||
          bus.req_ready_1 !== 1'b0 || bus.req_ready_0 !== 1'b0 || bus.M_en !== 1'b0)
        begin miscompares++; $display("FAIL bp_hold_%0d: valid=%b result=%h id=%b ready1=%b M_en=%b, want 1 2a 0 0 0",
          i, bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.req_ready_1, bus.M_en); end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready_1 !== 1'b1)
      begin miscompares++; $display("FAIL bp_release: busy=%b rsp_valid=%b ready1=%b, want 0 0 1",
        bus.busy, bus.rsp_valid, bus.req_ready_1); end
    @(negedge clk);
    bus.req_valid_1 = 1'b0;
    wait_rsp(to);
    vectors++;
    if (to || bus.rsp_result !== 32'h0001_0000 || bus.rsp_id !== 1'b1)
      begin miscompares++; $display("FAIL bp_second: timeout=%b result=%h id=%b, want 00010000 id 1",
        to, bus.rsp_result, bus.rsp_id); end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit to;
    bit seen;
    bus.req_src1_0 = 32'h0000_0009; bus.req_src2_0 = 32'h0000_0009; bus.req_valid_0 = 1'b1;
    #1;
    @(negedge clk);
    bus.req_valid_0 = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.M_en !== 1'b0 || bus.rsp_valid !== 1'b0)
      begin miscompares++; $display("FAIL rstmid_gated: busy=%b M_en=%b rsp_valid=%b, want 0 0 0",
        bus.busy, bus.M_en, bus.rsp_valid); end
    @(negedge clk); #1;
    reset_n = 1'b1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'h0)
      begin miscompares++; $display("FAIL rstmid_after: busy=%b rsp_valid=%b result=%h, want 0 0 0",
        bus.busy, bus.rsp_valid, bus.rsp_result); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL rstmid_no_rsp: activity after reset = %b, want 0", seen); end
    bus.req_src1_0 = 32'h0000_0003; bus.req_src2_0 = 32'h0000_0004; bus.req_valid_0 = 1'b1;
    bus.req_src1_1 = 32'h0000_0005; bus.req_src2_1 = 32'h0000_0006; bus.req_valid_1 = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready_0 !== 1'b1 || bus.req_ready_1 !== 1'b0)
      begin miscompares++; $display("FAIL rstmid_first: ready0=%b ready1=%b, want 1 0", bus.req_ready_0, bus.req_ready_1); end
    @(negedge clk);
    bus.req_valid_0 = 1'b0;
    wait_rsp(to);
    vectors++;
    if (to || bus.rsp_result !== 32'd12 || bus.rsp_id !== 1'b0)
      begin miscompares++; $display("FAIL rstmid_rsp0: timeout=%b result=%h id=%b, want 0000000c id 0",
        to, bus.rsp_result, bus.rsp_id); end
    @(negedge clk); #1;
    vectors++;
    if (bus.req_ready_1 !== 1'b1)
      begin miscompares++; $display("FAIL rstmid_second: ready1=%b, want 1", bus.req_ready_1); end
    @(negedge clk);
    bus.req_valid_1 = 1'b0;
    wait_rsp(to);
    vectors++;
    if (to || bus.rsp_result !== 32'd30 || bus.rsp_id !== 1'b1)
      begin miscompares++; $display("FAIL rstmid_rsp1: timeout=%b result=%h id=%b, want 0000001e id 1",
        to, bus.rsp_result, bus.rsp_id); end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_rsp();
    bit to;
    bus.rsp_ready = 1'b0;
    issue(1'b1, 32'h0000_0005, 32'h0000_0005, to);
    if (!to) wait_rsp(to);
    vectors++;
    if (to || bus.rsp_result !== 32'd25 || bus.rsp_id !== 1'b1)
      begin miscompares++; $display("FAIL rstrsp_pre: timeout=%b result=%h id=%b, want 00000019 id 1",
        to, bus.rsp_result, bus.rsp_id); end
    reset_n = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'h0 || bus.rsp_id !== 1'b0 || bus.busy !== 1'b0)
      begin miscompares++; $display("FAIL rstrsp_after: valid=%b result=%h id=%b busy=%b, want 0 0 0 0",
        bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.busy); end
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
    bus.req_src1_0 = 32'h0; bus.req_src2_0 = 32'h0;
    bus.req_src1_1 = 32'h0; bus.req_src2_1 = 32'h0;
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_reset_rsp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_cell_arbiter.md
# mul_cell_arbiter

Round-robin arbiter and sequencer that shares one three-partial-product 16x16 multiplier cell between two requesters. It sits between two CPU-side requesters and the cell. For each accepted 32x32 request it drives the cell's operand and enable inputs, combines the three 32-bit partial products into the low 32 bits of the product, and returns the result with a requester ID over a valid/ready response port. One operation is in flight at a time.

## Interface
- No parameters; all widths fixed at 32-bit operands and result.
- clk  in  1  single clock for all state.
- reset_n  in  1  reset, synchronous, active-low; sampled only on rising clk.
- req_valid_0 / req_valid_1  in  1  request valid per requester; held until the matching ready.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle.
- req_src1_0 / req_src1_1  in  32  multiplicand per requester.
- req_src2_0 / req_src2_1  in  32  multiplier per requester.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the result.
- rsp_result  out  32  low 32 bits of src1*src2; signedness is irrelevant.
- busy  out  1  high in every state except IDLE.
- E_src1 / E_src2  out  32  operands to the cell.
- M_en  out  1  cell register enable.
- M_mul_cell_p1 / p2 / p3  in  32 each  cell products, valid one enabled clock after operands are presented:
  - p1 = src1[15:0]*src2[15:0]
  - p2 = src1[15:0]*src2[31:16]
  - p3 = src1[31:16]*src2[15:0]

## Operation
- States are IDLE, MUL, SUM and RSP.
- **IDLE**
  - req_ready_x is high only in IDLE, combinationally granted.
  - One valid request: grant it.
  - Both valid: grant the requester other than last_grant.
  - On grant: latch src1/src2 into op1/op2, latch the ID into cur_id, set last_grant = ID, go to MUL.
  - At most one req_ready_x is high in any cycle.
- **MUL**
  - E_src1 = op1, E_src2 = op2, M_en = 1 for exactly this cycle; go to SUM.
- **SUM**
  - M_en = 0, so the cell holds.
  - Register rsp_result = p1 + {(p2[15:0] + p3[15:0]) mod 2^16, 16'h0}, all truncated to 32 bits.
  - Register rsp_id = cur_id; go to RSP.
- **RSP**
  - rsp_valid = 1.
  - rsp_result and rsp_id are stable while rsp_valid && !rsp_ready.
  - On rsp_ready go to IDLE.
- **Idle outputs**
  - M_en = 0 in every state except MUL.
  - E_src1/E_src2 drive op1/op2 at all times; their value matters only in MUL.
- **Reset** (reset_n low at a rising edge, in any state including mid-operation)
  - Next state IDLE; the in-flight operation is discarded with no response.
  - rsp_valid = 0, busy = 0, M_en = 0, req_ready_x = 0 while reset_n is low.
  - last_grant = 1, so requester 0 wins the first contention.
  - op1, op2, rsp_result = 0; rsp_id = 0, cur_id = 0.
- A request deasserted before it is granted is simply not serviced. The protocol requires holding valid until ready; a bench assertion flags violations.

## Timing
- Grant at edge k, when req_valid_x && req_ready_x.
  - MUL during cycle k..k+1; the cell captures on edge k+1.
  - SUM during k+1..k+2.
  - rsp_valid is high from edge k+2, i.e. the third cycle after the grant cycle.
- Minimum spacing between grants is 4 cycles, with rsp_ready held high.
  - The grant cycle is the last IDLE cycle; then MUL, SUM, RSP; IDLE again.
- Backpressure: RSP holds indefinitely. Requests arriving meanwhile see req_ready low and wait.
- Fairness: under continuous contention, grants alternate 0,1,0,1,...

## Test plan
- **Single multiply:** after reset, req_valid_0 with 0x00012345 * 0x00000010.
  - req_ready_0 high in the grant cycle; M_en high exactly one cycle.
  - rsp_valid 3 cycles after the grant cycle, with rsp_result = 0x00123450, rsp_id = 0.
- **Wrap and truncation:**
  - 0xFFFFFFFF * 0xFFFFFFFF gives 0x00000001.
  - 0x00010000 * 0x00010000 gives 0x00000000.
  - 0x0000FFFF * 0x00010001 gives 0xFFFFFFFF.
- **Contention:** both requesters valid continuously with distinct operands, rsp_ready = 1.
  - Grant order is 0,1,0,1; rsp_id order matches.
  - Grants are exactly 4 cycles apart.
- **Backpressure:** hold rsp_ready = 0 for 10 cycles in RSP.
  - rsp_result and rsp_id stay stable; req_ready_x stays low; M_en stays 0.
  - Raise rsp_ready: IDLE next cycle, and the pending requester is granted in that IDLE cycle.
- **Reset mid-operation:** assert reset_n low for one cycle while in SUM.
  - No rsp_valid; busy = 0 the next cycle.
  - Requester 0 wins a subsequent simultaneous request.
- **Reset in RSP:** reset_n low while rsp_valid = 1.
  - rsp_valid = 0 after that edge; rsp_result = 0.
